// File: rtl/evm_ctrl.sv
// Electronic voting machine controller: ballot arming, per-candidate counters, confirmation LED, poll close.
// Optional feature: define EVM_TOTAL_EN to add a saturating running total of acknowledged votes.
module evm_ctrl #(
    parameter int NUM_CAND = 9,
    parameter int CNT_W    = 8,
    parameter int LED_HOLD = 4,
    localparam int SEL_W   = $clog2(NUM_CAND + 1),
    localparam int TOT_W   = CNT_W + $clog2(NUM_CAND)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ballot_en,
    input  logic                      poll_close,
    input  logic                      vote_valid,
    input  logic [SEL_W-1:0]          button,
    output logic                      ballot_ready,
    output logic                      vote_ack,
    output logic                      vote_err,
    output logic [NUM_CAND*CNT_W-1:0] counts,
    output logic [NUM_CAND-1:0]       led,
    output logic [NUM_CAND-1:0]       sat,
    output logic                      closed
`ifdef EVM_TOTAL_EN
    ,
    output logic [TOT_W-1:0]          total
`endif
);

    localparam int HOLD_W = (LED_HOLD > 1) ? $clog2(LED_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LED_HOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, ARMED, SHOW, CLOSED} state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [HOLD_W-1:0]   hold_reg;
    logic [NUM_CAND-1:0] led_reg;
    logic [NUM_CAND-1:0] hit;
    logic                ack_reg;
    logic                err_reg;
    logic                btn_valid;
    logic                vote_accept;
    logic                vote_reject;

    // poll_close masks any press in the same cycle, so neither ack nor err can fire
    assign btn_valid   = (button != '0) && (button <= SEL_W'(NUM_CAND));
    assign vote_accept = (state_reg == ARMED) && vote_valid && btn_valid && !poll_close;
    assign vote_reject = (state_reg == ARMED) && vote_valid && !btn_valid && !poll_close;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ballot_en) state_next = ARMED;
            ARMED:   if (vote_accept) state_next = SHOW;
            SHOW:    if (hold_reg == HOLD_LAST) state_next = IDLE;
            CLOSED:  state_next = CLOSED;
            default: state_next = IDLE;
        endcase
        if (poll_close) begin
            state_next = CLOSED;
        end
    end

    always_comb begin
        ballot_ready = (state_reg == ARMED);
        closed       = (state_reg == CLOSED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg <= '0;
            led_reg  <= '0;
            ack_reg  <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            ack_reg <= vote_accept;
            err_reg <= vote_reject;
            if (vote_accept) begin
                hold_reg <= '0;
            end else if (state_reg == SHOW) begin
                hold_reg <= hold_reg + 1'b1;
            end
            // led survives only while the machine stays in SHOW
            if (vote_accept) begin
                led_reg <= hit;
            end else if (state_next != SHOW) begin
                led_reg <= '0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CAND; gi++) begin : gen_cand
            logic [CNT_W-1:0] cnt_reg;
            logic             sat_reg;

            assign hit[gi] = vote_accept && (button == SEL_W'(gi + 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                    sat_reg <= 1'b0;
                end else if (hit[gi]) begin
                    if (cnt_reg == CNT_MAX) begin
                        sat_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign counts[gi*CNT_W +: CNT_W] = cnt_reg;
            assign sat[gi]                   = sat_reg;
        end
    endgenerate

    assign led      = led_reg;
    assign vote_ack = ack_reg;
    assign vote_err = err_reg;

`ifdef EVM_TOTAL_EN
    logic [TOT_W-1:0] total_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_reg <= '0;
        end else if (vote_accept && (total_reg != {TOT_W{1'b1}})) begin
            total_reg <= total_reg + 1'b1;
        end
    end

    assign total = total_reg;
`endif

endmodule

// File: tb/tb_evm_ctrl.sv
// Directed bench for evm_ctrl: a default instance plus a CNT_W=2 instance sharing the same stimulus.
module tb_evm_ctrl;

    localparam int NC = 9;
    localparam int HOLD = 4;

    logic        clk;
    logic        rst_n;
    logic        ballot_en;
    logic        poll_close;
    logic        vote_valid;
    logic [3:0]  button;

    logic        ballot_ready, vote_ack, vote_err, closed;
    logic [NC*8-1:0] counts;
    logic [NC-1:0]   led, sat;

    logic        ready2, ack2, err2, closed2;
    logic [NC*2-1:0] counts2;
    logic [NC-1:0]   led2, sat2;

`ifdef EVM_TOTAL_EN
    logic [11:0] total;
    logic [5:0]  total2;
`endif

    int checks = 0;
    int failures = 0;

    evm_ctrl #(.NUM_CAND(NC), .CNT_W(8), .LED_HOLD(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .ballot_en(ballot_en), .poll_close(poll_close),
        .vote_valid(vote_valid), .button(button), .ballot_ready(ballot_ready),
        .vote_ack(vote_ack), .vote_err(vote_err), .counts(counts), .led(led),
        .sat(sat), .closed(closed)
`ifdef EVM_TOTAL_EN
        , .total(total)
`endif
    );

    evm_ctrl #(.NUM_CAND(NC), .CNT_W(2), .LED_HOLD(HOLD)) dut2 (
        .clk(clk), .rst_n(rst_n), .ballot_en(ballot_en), .poll_close(poll_close),
        .vote_valid(vote_valid), .button(button), .ballot_ready(ready2),
        .vote_ack(ack2), .vote_err(err2), .counts(counts2), .led(led2),
        .sat(sat2), .closed(closed2)
`ifdef EVM_TOTAL_EN
        , .total(total2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       ben;
        logic       vv;
        logic [3:0] btn;
        logic       e_ready;
        logic       e_ack;
        logic       e_err;
        logic [8:0] e_led;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt(input int k);
        return 32'(counts[k*8 +: 8]);
    endfunction

    function automatic logic [31:0] cnt2(input int k);
        return 32'(counts2[k*2 +: 2]);
    endfunction

    task automatic do_reset();
        rst_n      = 1'b0;
        ballot_en  = 1'b0;
        poll_close = 1'b0;
        vote_valid = 1'b0;
        button     = 4'd0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic vote(input logic [3:0] b, output logic a1, output logic a2);
        ballot_en = 1'b1;
        tick();
        ballot_en  = 1'b0;
        vote_valid = 1'b1;
        button     = b;
        tick();
        a1 = vote_ack;
        a2 = ack2;
        vote_valid = 1'b0;
        button     = 4'd0;
        repeat (HOLD) tick();
        $display("vote button=%0d ack=%0d ack2=%0d", b, a1, a2);
    endtask

    initial begin
        logic a1, a2;
        int   acks2;
        int   exp36 [NC];

        rst_n      = 1'b0;
        ballot_en  = 1'b0;
        poll_close = 1'b0;
        vote_valid = 1'b0;
        button     = 4'd0;

        vecs[0]  = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 9'h000};
        vecs[1]  = '{1'b0, 1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 9'h001};
        vecs[2]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 9'h001};
        vecs[3]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 9'h001};
        vecs[4]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 9'h001};
        vecs[5]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 9'h000};
        vecs[6]  = '{1'b0, 1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 9'h000};
        vecs[7]  = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 9'h000};
        vecs[8]  = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 9'h000};
        vecs[9]  = '{1'b0, 1'b1, 4'd10, 1'b1, 1'b0, 1'b1, 9'h000};
        vecs[10] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 9'h000};
        vecs[11] = '{1'b0, 1'b1, 4'd2,  1'b0, 1'b1, 1'b0, 9'h002};
        vecs[12] = '{1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 9'h002};
        vecs[13] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 9'h002};
        vecs[14] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 9'h002};
        vecs[15] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 9'h000};

        exp36 = '{2, 0, 1, 1, 1, 0, 0, 0, 0};

        // Reset state
        do_reset();
        check("rst_ready", 32'(ballot_ready), 0);
        check("rst_ack", 32'(vote_ack), 0);
        check("rst_err", 32'(vote_err), 0);
        check("rst_led", 32'(led), 0);
        check("rst_sat", 32'(sat), 0);
        check("rst_closed", 32'(closed), 0);
        check("rst_counts_lo", counts[31:0], 0);
        check("rst_counts_hi", 32'(counts[71:32]), 0);

        // Cycle-by-cycle single vote, invalid presses, SHOW ignoring inputs
        for (int i = 0; i < 16; i++) begin
            ballot_en  = vecs[i].ben;
            vote_valid = vecs[i].vv;
            button     = vecs[i].btn;
            tick();
            $display("vec %0d ready=%0d ack=%0d err=%0d led=%03h", i, ballot_ready, vote_ack, vote_err, led);
            check($sformatf("vec%0d_ready", i), 32'(ballot_ready), 32'(vecs[i].e_ready));
            check($sformatf("vec%0d_ack", i), 32'(vote_ack), 32'(vecs[i].e_ack));
            check($sformatf("vec%0d_err", i), 32'(vote_err), 32'(vecs[i].e_err));
            check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].e_led));
        end
        ballot_en  = 1'b0;
        vote_valid = 1'b0;
        button     = 4'd0;
        check("tbl_cnt0", cnt(0), 1);
        check("tbl_cnt1", cnt(1), 1);
        check("tbl_cnt2", cnt(2), 0);

        // Mixed ballots
        do_reset();
        vote(4'd1, a1, a2);
        vote(4'd5, a1, a2);
        vote(4'd3, a1, a2);
        vote(4'd4, a1, a2);
        vote(4'd1, a1, a2);
        for (int k = 0; k < NC; k++) begin
            check($sformatf("mix_cnt%0d", k), cnt(k), 32'(exp36[k]));
        end

        // Saturation on the narrow instance
        do_reset();
        acks2 = 0;
        for (int n = 0; n < 4; n++) begin
            vote(4'd3, a1, a2);
            acks2 += int'(a2);
        end
        check("sat_acks", 32'(acks2), 4);
        check("sat_cnt2", cnt2(2), 3);
        check("sat_flag2", 32'(sat2), 32'h004);
        check("sat_wide_cnt", cnt(2), 4);
        check("sat_wide_flag", 32'(sat), 0);
`ifdef EVM_TOTAL_EN
        check("sat_total2", 32'(total2), 4);
        check("sat_total", 32'(total), 4);
`endif

        // poll_close beats a simultaneous vote, then absorbs
        do_reset();
        ballot_en = 1'b1;
        tick();
        ballot_en = 1'b0;
        check("pc_ready_armed", 32'(ballot_ready), 1);
        vote_valid = 1'b1;
        button     = 4'd1;
        poll_close = 1'b1;
        tick();
        $display("poll_close with vote ack=%0d closed=%0d", vote_ack, closed);
        check("pc_ack", 32'(vote_ack), 0);
        check("pc_closed", 32'(closed), 1);
        check("pc_ready", 32'(ballot_ready), 0);
        check("pc_cnt0", cnt(0), 0);
        poll_close = 1'b0;
        vote_valid = 1'b0;
        ballot_en  = 1'b1;
        repeat (2) tick();
        check("pc_ben_ignored", 32'(ballot_ready), 0);
        vote_valid = 1'b1;
        tick();
        check("pc_late_ack", 32'(vote_ack), 0);
        check("pc_late_closed", 32'(closed), 1);
        check("pc_late_led", 32'(led), 0);
        check("pc_late_cnt0", cnt(0), 0);
        ballot_en  = 1'b0;
        vote_valid = 1'b0;
        button     = 4'd0;

        // Reset pulse mid-SHOW after three votes
        do_reset();
        vote(4'd1, a1, a2);
        vote(4'd2, a1, a2);
        vote(4'd3, a1, a2);
        check("rs_pre_cnt0", cnt(0), 1);
        ballot_en = 1'b1;
        tick();
        ballot_en  = 1'b0;
        vote_valid = 1'b1;
        button     = 4'd4;
        tick();
        vote_valid = 1'b0;
        button     = 4'd0;
        tick();
        check("rs_led_show", 32'(led), 32'h008);
        rst_n = 1'b0;
        #1;
        check("rs_async_counts", counts[31:0], 0);
        check("rs_async_led", 32'(led), 0);
        tick();
        rst_n = 1'b1;
        $display("mid-SHOW reset released counts=%018h led=%03h", counts, led);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rs_cnt%0d", k), cnt(k), 0);
        end
        check("rs_led", 32'(led), 0);
        check("rs_ready", 32'(ballot_ready), 0);
        ballot_en = 1'b1;
        tick();
        ballot_en = 1'b0;
        check("rs_rearm", 32'(ballot_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/evm_ctrl.md
EVM_CTRL -- requirements
Module: evm_ctrl

Interface
REQ-001 SHALL have parameter NUM_CAND, default 9, meaning the number of candidates (2..32).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the per-candidate vote counter width.
REQ-003 SHALL have parameter LED_HOLD, default 4, meaning the number of cycles the confirmation LED stays lit (>=1).
REQ-004 SHALL define localparam SEL_W = $clog2(NUM_CAND+1).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port ballot_en, input, 1 bit: officer issues one ballot (level sampled per cycle).
REQ-008 SHALL have port poll_close, input, 1 bit: ends polling permanently until reset.
REQ-009 SHALL have port vote_valid, input, 1 bit: voter press strobe.
REQ-010 SHALL have port button, input, SEL_W bits: candidate index, 1..NUM_CAND valid; 0 and >NUM_CAND invalid.
REQ-011 SHALL have port ballot_ready, output, 1 bit: high while a ballot is armed.
REQ-012 SHALL have port vote_ack, output, 1 bit: one-cycle pulse when a vote is recorded.
REQ-013 SHALL have port vote_err, output, 1 bit: one-cycle pulse on an invalid press while armed.
REQ-014 SHALL have port counts, output, NUM_CAND*CNT_W bits: candidate k's count in bits [k*CNT_W +: CNT_W], where k = button-1.
REQ-015 SHALL have port led, output, NUM_CAND bits: one-hot confirmation of the last vote.
REQ-016 SHALL have port sat, output, NUM_CAND bits: sticky per-candidate saturation flags.
REQ-017 SHALL have port closed, output, 1 bit: high once polling is closed.

Function
REQ-018 SHALL implement the FSM states IDLE, ARMED, SHOW and CLOSED.
REQ-019 SHALL move IDLE -> ARMED on ballot_en=1, and SHALL assert ballot_ready from the next cycle.
REQ-020 SHALL, in ARMED with vote_valid=1 and a valid button, increment count[button-1] by one, pulse vote_ack, set led[button-1], and move to SHOW, all in the same edge.
REQ-021 SHALL, in ARMED with vote_valid=1 and an invalid button, pulse vote_err and stay in ARMED, with no count change.
REQ-022 SHALL hold led for exactly LED_HOLD cycles in SHOW, then clear led and return to IDLE.
REQ-023 SHALL ignore ballot_en and vote_valid while in SHOW.
REQ-024 SHALL ignore vote_valid in IDLE (no ack, no err), so at most one vote is recorded per ballot.
REQ-025 SHALL saturate a counter at 2^CNT_W-1; a vote for a saturated candidate still acks but leaves the count unchanged and sets sat[k].
REQ-026 SHALL move any state -> CLOSED on poll_close=1; CLOSED is absorbing until reset and asserts closed.
REQ-027 SHALL give poll_close priority over a vote in the same cycle: the vote is not counted and no ack is issued.
REQ-028 SHALL keep counts readable and frozen in CLOSED, with led cleared and ballot_ready=0.
REQ-029 SHALL treat ballot_en held high as a single ballot; re-arming requires passing through SHOW and IDLE again.

Reset
REQ-030 SHALL, on rst_n=0 (asynchronous), force state to IDLE, all counts to 0, led=0, sat=0, vote_ack=0, vote_err=0, ballot_ready=0 and closed=0.
REQ-031 SHALL leave counts at 0 when reset is asserted mid-SHOW or mid-ARMED, with no partial vote retained.
REQ-032 SHALL release reset synchronously to clk in its effect: the first transition occurs on the first rising edge with rst_n=1.

Configuration
REQ-033 SHALL, when macro EVM_TOTAL_EN is defined, add output total, width CNT_W+$clog2(NUM_CAND), counting every acked vote including saturated-candidate votes; total resets to 0 and saturates at its maximum.
REQ-034 SHALL, without EVM_TOTAL_EN, have no total port and no associated logic.

Verification
REQ-035 SHALL cover: reset, ballot_en, then button=1 with valid -> vote_ack 1 cycle, counts[0]=1, led=9'b000000001 for 4 cycles, then IDLE.
REQ-036 SHALL cover: ballots for buttons 1,5,3,4,1 -> counts[0]=2, counts[2]=1, counts[3]=1, counts[4]=1, all others 0.
REQ-037 SHALL cover: armed press with button=0 and then button=10 -> two vote_err pulses, no count change, still ARMED; then button=2 -> counts[1]=1.
REQ-038 SHALL cover: CNT_W=2, four votes for candidate 3 -> counts[2]=3, sat[2]=1, four acks; with EVM_TOTAL_EN, total=4.
REQ-039 SHALL cover: poll_close in the same cycle as a valid vote -> no ack, counts unchanged, closed=1; a later ballot_en is ignored.
REQ-040 SHALL cover: rst_n low for 1 cycle mid-SHOW after 3 votes -> all counts 0, led 0, IDLE.
